// File: rtl/axi4_ar_sender.sv
// Read-address stage of one RAB slice: holds one AR, runs a translation lookup,
// then forwards it with the translated address or drops it with a trans_drop pulse.
module axi4_ar_sender #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arst,
  input  logic                      s_axi4_arvalid,
  output logic                      s_axi4_arready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi4_araddr,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi4_arid,
  input  logic [7:0]                s_axi4_arlen,
  input  logic [2:0]                s_axi4_arsize,
  input  logic [1:0]                s_axi4_arburst,
  input  logic [2:0]                s_axi4_arprot,
  input  logic [AXI_USER_WIDTH-1:0] s_axi4_aruser,
  output logic                      lookup_req,
  output logic [AXI_ADDR_WIDTH-1:0] lookup_addr,
  output logic [AXI_ID_WIDTH-1:0]   lookup_id,
  input  logic                      lookup_done,
  input  logic                      lookup_hit,
  input  logic                      lookup_prot_err,
  input  logic                      lookup_prefetch,
  input  logic [AXI_ADDR_WIDTH-1:0] lookup_out_addr,
  output logic                      m_axi4_arvalid,
  input  logic                      m_axi4_arready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi4_araddr,
  output logic [AXI_ID_WIDTH-1:0]   m_axi4_arid,
  output logic [7:0]                m_axi4_arlen,
  output logic [2:0]                m_axi4_arsize,
  output logic [1:0]                m_axi4_arburst,
  output logic [2:0]                m_axi4_arprot,
  output logic [AXI_USER_WIDTH-1:0] m_axi4_aruser,
  output logic                      trans_drop,
  output logic [AXI_ID_WIDTH-1:0]   trans_id,
  output logic                      trans_prefetch,
  output logic                      trans_hit,
  output logic [CNT_WIDTH-1:0]      drop_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FWD    = 2'd2,
    DROP   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t                    r_state;
  logic                      r_arready;
  logic                      r_lookup_req;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [7:0]                r_len;
  logic [2:0]                r_size;
  logic [1:0]                r_burst;
  logic [2:0]                r_prot;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_m_valid;
  logic [AXI_ADDR_WIDTH-1:0] r_m_addr;
  logic [AXI_ID_WIDTH-1:0]   r_m_id;
  logic [7:0]                r_m_len;
  logic [2:0]                r_m_size;
  logic [1:0]                r_m_burst;
  logic [2:0]                r_m_prot;
  logic [AXI_USER_WIDTH-1:0] r_m_user;
  logic                      r_drop;
  logic [AXI_ID_WIDTH-1:0]   r_drop_id;
  logic                      r_drop_pf;
  logic                      r_drop_hit;
  logic [CNT_WIDTH-1:0]      r_cnt;

  logic w_ar_hs;
  logic w_fwd;

  assign w_ar_hs = s_axi4_arvalid & r_arready;
  // prot_err and prefetch both veto forwarding even on a hit
  assign w_fwd   = lookup_hit & ~lookup_prot_err & ~lookup_prefetch;

  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) begin
      r_state      <= IDLE;
      r_arready    <= 1'b0;
      r_lookup_req <= 1'b0;
      r_addr       <= '0;
      r_id         <= '0;
      r_len        <= 8'd0;
      r_size       <= 3'd0;
      r_burst      <= 2'd0;
      r_prot       <= 3'd0;
      r_user       <= '0;
      r_m_valid    <= 1'b0;
      r_m_addr     <= '0;
      r_m_id       <= '0;
      r_m_len      <= 8'd0;
      r_m_size     <= 3'd0;
      r_m_burst    <= 2'd0;
      r_m_prot     <= 3'd0;
      r_m_user     <= '0;
      r_drop       <= 1'b0;
      r_drop_id    <= '0;
      r_drop_pf    <= 1'b0;
      r_drop_hit   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ar_hs) begin
            r_addr       <= s_axi4_araddr;
            r_id         <= s_axi4_arid;
            r_len        <= s_axi4_arlen;
            r_size       <= s_axi4_arsize;
            r_burst      <= s_axi4_arburst;
            r_prot       <= s_axi4_arprot;
            r_user       <= s_axi4_aruser;
            r_arready    <= 1'b0;
            r_lookup_req <= 1'b1;
            r_state      <= LOOKUP;
          end else begin
            r_arready    <= 1'b1;
          end
        end
        LOOKUP: begin
          if (lookup_done) begin
            r_lookup_req <= 1'b0;
            if (w_fwd) begin
              r_m_valid <= 1'b1;
              r_m_addr  <= lookup_out_addr;
              r_m_id    <= r_id;
              r_m_len   <= r_len;
              r_m_size  <= r_size;
              r_m_burst <= r_burst;
              r_m_prot  <= r_prot;
              r_m_user  <= r_user;
              r_state   <= FWD;
            end else begin
              r_drop     <= 1'b1;
              r_drop_id  <= r_id;
              r_drop_pf  <= lookup_hit & lookup_prefetch;
              r_drop_hit <= lookup_hit & ~lookup_prot_err;
              if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_ONE;
              end else begin
                r_cnt <= r_cnt;
              end
              r_state    <= DROP;
            end
          end else begin
            r_lookup_req <= 1'b1;
          end
        end
        FWD: begin
          if (m_axi4_arready) begin
            r_m_valid <= 1'b0;
            r_m_addr  <= '0;
            r_m_id    <= '0;
            r_m_len   <= 8'd0;
            r_m_size  <= 3'd0;
            r_m_burst <= 2'd0;
            r_m_prot  <= 3'd0;
            r_m_user  <= '0;
            r_arready <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_m_valid <= 1'b1;
          end
        end
        DROP: begin
          r_drop     <= 1'b0;
          r_drop_id  <= '0;
          r_drop_pf  <= 1'b0;
          r_drop_hit <= 1'b0;
          r_arready  <= 1'b1;
          r_state    <= IDLE;
        end
        default: begin
          r_state      <= IDLE;
          r_arready    <= 1'b0;
          r_lookup_req <= 1'b0;
          r_m_valid    <= 1'b0;
          r_drop       <= 1'b0;
        end
      endcase
    end
  end

  assign s_axi4_arready = r_arready;
  assign lookup_req     = r_lookup_req;
  assign lookup_addr    = r_addr;
  assign lookup_id      = r_id;
  assign m_axi4_arvalid = r_m_valid;
  assign m_axi4_araddr  = r_m_addr;
  assign m_axi4_arid    = r_m_id;
  assign m_axi4_arlen   = r_m_len;
  assign m_axi4_arsize  = r_m_size;
  assign m_axi4_arburst = r_m_burst;
  assign m_axi4_arprot  = r_m_prot;
  assign m_axi4_aruser  = r_m_user;
  assign trans_drop     = r_drop;
  assign trans_id       = r_drop_id;
  assign trans_prefetch = r_drop_pf;
  assign trans_hit      = r_drop_hit;
  assign drop_count     = r_cnt;

endmodule
